test_monitor: RTL

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/test_monitor.sv
// End-of-test monitor for ISA-style self-checking programs: detects completion by PC match
// or tohost store, records the pass/fail verdict, failing test number and run length.
module test_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     MODE        = 0,
  parameter logic [XLEN-1:0] PASS_PC     = XLEN'(32'h44),
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h1000),
  parameter int unsigned     TIMEOUT     = 5000,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   gp,
  input  logic              st_valid,
  input  logic [XLEN-1:0]   st_addr,
  input  logic [XLEN-1:0]   st_data,
  output logic              busy,
  output logic              done,
  output logic              done_p,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [XLEN-2:0]   test_num,
  output logic [CNT_W-1:0]  cycles
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TMO  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_p_q, done_p_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             tmo_q, tmo_d;
  logic [XLEN-2:0]  test_num_q, test_num_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic             hit_c;
  logic [XLEN-1:0]  code_c;

  // Completion source: PC reaching the pass address (code in gp) or a nonzero tohost store.
  always_comb begin
    hit_c  = 1'b0;
    code_c = '0;
    if (MODE == 0) begin
      hit_c  = (pc == PASS_PC);
      code_c = gp;
    end else begin
      hit_c  = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
      code_c = st_data;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tmo_d      = tmo_q;
    done_p_d   = 1'b0;
    test_num_d = test_num_q;
    cycles_d   = cycles_q;

    case (state_q)
      S_IDLE, S_PASS, S_FAIL, S_TMO: begin
        if (start) begin
          state_d    = S_RUN;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          tmo_d      = 1'b0;
          test_num_d = '0;
          cycles_d   = '0;
        end
      end
      S_RUN: begin
        // Completion outranks timeout; cycles freezes on the exit edge.
        if (hit_c) begin
          done_p_d = 1'b1;
          if (code_c == XLEN'(1)) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d    = S_FAIL;
            fail_d     = 1'b1;
            test_num_d = code_c[XLEN-1:1];
          end
        end else if (cycles_q == LAST_CYCLE) begin
          state_d  = S_TMO;
          tmo_d    = 1'b1;
          done_p_d = 1'b1;
        end else begin
          cycles_d = cycles_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = pass_d | fail_d | tmo_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_p_q   <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      test_num_q <= '0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_p_q   <= done_p_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      test_num_q <= test_num_d;
      cycles_q   <= cycles_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign done_p   = done_p_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = tmo_q;
  assign test_num = test_num_q;
  assign cycles   = cycles_q;

endmodule
